// File: rtl/alu_pkg.sv
// Shared opcode constants, class/state enums and the opcode class decoder for alu_sched.
package alu_pkg;

  localparam int ALU_OPC_W = 6;

  localparam logic [ALU_OPC_W-1:0] OPC_RTYPE = 6'b000000;
  localparam logic [ALU_OPC_W-1:0] OPC_BEQ   = 6'b000100;
  localparam logic [ALU_OPC_W-1:0] OPC_BNE   = 6'b000101;
  localparam logic [ALU_OPC_W-1:0] OPC_BLE   = 6'b000110;
  localparam logic [ALU_OPC_W-1:0] OPC_BGT   = 6'b000111;
  localparam logic [ALU_OPC_W-1:0] OPC_J     = 6'b111111;
  localparam logic [ALU_OPC_W-1:0] OPC_JR    = 6'b111110;
  localparam logic [ALU_OPC_W-1:0] OPC_JAL   = 6'b111101;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_J
  } alu_class_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } sched_state_t;

  function automatic alu_class_t alu_class_of(input logic [ALU_OPC_W-1:0] opcode);
    alu_class_t cls;
    case (opcode)
      OPC_RTYPE: cls = CLS_R;
      OPC_BEQ, OPC_BNE, OPC_BLE, OPC_BGT,
      OPC_J, OPC_JR, OPC_JAL: cls = CLS_J;
      default: cls = CLS_I;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the other port after each update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  always_comb begin
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    last_d = update ? grant[1] : last_q;
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Schedules the shared ALU between execute (port 0) and branch resolver (port 1).
// Optional per-port grant and stall counters are enabled by defining ALU_SCHED_PERF_EN.
module alu_sched
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [31:0]       req_instr0,
  input  logic [31:0]       req_instr1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_c,
  output logic              rsp_branch,
  output logic [31:0]       alu_instruction,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_rtype,
  output logic              alu_itype,
  output logic              alu_jtype,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_branch
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_stall
`endif
);

  sched_state_t      state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              g_q, g_d;
  alu_class_t        cls_q, cls_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic              br_q, br_d;

  logic [1:0]        arb_req;
  logic [1:0]        grant;
  logic              hs;
  logic              hs_port;
  logic [31:0]       sel_instr;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OPC_W-1:0]  sel_opc;

  // Arbitration is only offered in IDLE and never while reset is asserted.
  always_comb begin
    arb_req = (state_q == IDLE && !rst) ? req_valid : '0;
  end

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (arb_req),
    .update (hs),
    .grant  (grant)
  );

  always_comb begin
    req_ready = grant & arb_req;
    hs        = |req_ready;
    hs_port   = req_ready[1];
    sel_instr = hs_port ? req_instr1 : req_instr0;
    sel_a     = hs_port ? req_a1 : req_a0;
    sel_b     = hs_port ? req_b1 : req_b0;
    sel_opc   = sel_instr[31 -: OPC_W];
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    cls_d   = cls_q;
    c_d     = c_q;
    br_d    = br_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = ISSUE;
          instr_d = sel_instr;
          a_d     = sel_a;
          b_d     = sel_b;
          g_d     = hs_port;
          cls_d   = alu_class_of(sel_opc);
        end
      end
      ISSUE: begin
        state_d = RESP;
        c_d     = alu_c;
        br_d    = (cls_q == CLS_J) ? alu_branch : 1'b0;
      end
      RESP: begin
        if (rsp_ready[g_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= 1'b0;
      cls_q   <= CLS_R;
      c_q     <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      cls_q   <= cls_d;
      c_q     <= c_d;
      br_q    <= br_d;
    end
  end

  always_comb begin
    alu_instruction = instr_q;
    alu_a           = a_q;
    alu_b           = b_q;
    alu_rtype       = (state_q == ISSUE) && (cls_q == CLS_R);
    alu_itype       = (state_q == ISSUE) && (cls_q == CLS_I);
    alu_jtype       = (state_q == ISSUE) && (cls_q == CLS_J);
    rsp_valid       = (state_q == RESP) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_c           = c_q;
    rsp_branch      = br_q;
  end

`ifdef ALU_SCHED_PERF_EN
  logic [31:0] grant0_q, grant0_d;
  logic [31:0] grant1_q, grant1_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    grant0_d = grant0_q + {31'b0, hs & ~hs_port};
    grant1_d = grant1_q + {31'b0, hs & hs_port};
    stall_d  = stall_q + {31'b0, |(req_valid & ~req_ready)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant0_q <= '0;
      grant1_q <= '0;
      stall_q  <= '0;
    end else begin
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    perf_grant0 = grant0_q;
    perf_grant1 = grant1_q;
    perf_stall  = stall_q;
  end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched with a behavioural ALU and reference model.
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_instr0, req_instr1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_c;
  logic        rsp_branch;
  logic [31:0] alu_instruction;
  logic [31:0] alu_a, alu_b;
  logic        alu_rtype, alu_itype, alu_jtype;
  logic [31:0] alu_c;
  logic        alu_branch;

  logic        vld0, vld1;
  logic        rr_rand;
  logic [1:0]  rr_dir;
  logic [1:0]  rr_rnd;

  assign req_valid = {vld1, vld0};
  assign rsp_ready = rr_rand ? rr_rnd : rr_dir;

  alu_sched #(.DATA_W(32), .OPC_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_instr0      (req_instr0),
    .req_instr1      (req_instr1),
    .req_a0          (req_a0),
    .req_a1          (req_a1),
    .req_b0          (req_b0),
    .req_b1          (req_b1),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_c           (rsp_c),
    .rsp_branch      (rsp_branch),
    .alu_instruction (alu_instruction),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_rtype       (alu_rtype),
    .alu_itype       (alu_itype),
    .alu_jtype       (alu_jtype),
    .alu_c           (alu_c),
    .alu_branch      (alu_branch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] c;
    logic        br;
  } res_t;

  typedef struct {
    int          port;
    logic [31:0] c;
    logic        br;
    int          t;
  } exp_t;

  exp_t        sb_q[$];
  int          hs_log[$];
  int          checks = 0;
  int          passes = 0;
  int          hs_count[2];
  int          resp_count = 0;
  int          last_hs = -10;
  logic [31:0] last_hs_instr;
  logic [31:0] last_c_port[2];
  logic        last_br_port[2];
  int          rcnt = 0, icnt = 0, jcnt = 0;

  // Class from opcode: 0 = rtype, 1 = itype, 2 = jtype.
  function automatic int cls_of(input logic [5:0] op);
    if (op == 6'd0) return 0;
    if (op inside {6'd4, 6'd5, 6'd6, 6'd7, 6'd63, 6'd62, 6'd61}) return 2;
    return 1;
  endfunction

  // Behavioural ALU; class 3 (no strobe) returns junk so a missed strobe is visible.
  function automatic res_t alu_exec(input int cls, input logic [31:0] instr,
                                    input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [31:0] imm;
    imm = {{16{instr[15]}}, instr[15:0]};
    r.c = 32'hDEAD_BEEF;
    r.br = 1'b1;
    case (cls)
      0: begin
        case (instr[5:0])
          6'b100000: r.c = a + b;
          6'b100010: r.c = a - b;
          6'b100100: r.c = a & b;
          6'b100101: r.c = a | b;
          6'b101010: r.c = {31'b0, $signed(a) < $signed(b)};
          default:   r.c = a ^ b;
        endcase
        r.br = ^r.c;
      end
      1: begin
        case (instr[31:26])
          6'b001000: r.c = a + imm;
          6'b101010: r.c = {31'b0, $signed(a) < $signed(imm)};
          default:   r.c = a ^ {16'b0, instr[15:0]};
        endcase
        r.br = ^r.c;
      end
      2: begin
        r.c = a + imm;
        case (instr[31:26])
          6'd4:    r.br = (a == b);
          6'd5:    r.br = (a != b);
          6'd6:    r.br = ($signed(a) <= $signed(b));
          6'd7:    r.br = ($signed(a) > $signed(b));
          default: r.br = 1'b1;
        endcase
      end
      default: ;
    endcase
    return r;
  endfunction

  int   str_cls;
  res_t alu_res;
  assign str_cls = alu_rtype ? 0 : alu_itype ? 1 : alu_jtype ? 2 : 3;
  always_comb alu_res = alu_exec(str_cls, alu_instruction, alu_a, alu_b);
  assign alu_c      = alu_res.c;
  assign alu_branch = alu_res.br;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rr_rnd = 2'($urandom);
    end
  end

  // Monitor: scoreboard pop/compare, hold stability and ALU strobe timing.
  logic        held = 1'b0;
  logic [31:0] held_c;
  logic        held_br;
  logic [1:0]  held_v;
  exp_t        me;
  logic [2:0]  es;

  always @(negedge clk) begin
    if (cyc > 2) begin
      es = 3'b000;
      if (cyc == last_hs + 1) begin
        es = 3'b001 << cls_of(alu_instruction[31:26]);
        chk("alu_instr", alu_instruction, last_hs_instr);
      end
      chk("alu_strobes", {alu_jtype, alu_itype, alu_rtype}, es);
      chk("req_ready_legal", ((req_ready & ~req_valid) == 2'b00) && (req_ready != 2'b11), 1);
      if (alu_rtype) rcnt++;
      if (alu_itype) icnt++;
      if (alu_jtype) jcnt++;
    end
    if (rst) begin
      sb_q.delete();
      held = 1'b0;
    end else if (rsp_valid != 2'b00) begin
      if (!held) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 0);
        end else begin
          me = sb_q[0];
          chk("rsp_port", rsp_valid, 2'b01 << me.port);
          chk("rsp_latency", cyc, me.t + 2);
          chk("rsp_c", rsp_c, me.c);
          chk("rsp_branch", rsp_branch, me.br);
        end
        held = 1'b1;
        held_c = rsp_c;
        held_br = rsp_branch;
        held_v = rsp_valid;
      end else begin
        chk("rsp_c_stable", rsp_c, held_c);
        chk("rsp_branch_stable", rsp_branch, held_br);
        chk("rsp_valid_stable", rsp_valid, held_v);
      end
      chk("req_ready_busy", req_ready, 0);
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sb_q.size() > 0) begin
          me = sb_q.pop_front();
          last_c_port[me.port] = rsp_c;
          last_br_port[me.port] = rsp_branch;
        end
        held = 1'b0;
        resp_count++;
      end
    end else if (held) begin
      chk("rsp_held", rsp_valid, held_v);
      held = 1'b0;
    end
  end

  task automatic send(input int p, input logic [31:0] instr, input logic [31:0] a,
                      input logic [31:0] b);
    int   waited;
    int   other0;
    bit   got;
    int   cls;
    res_t r;
    exp_t e;
    if (p == 0) begin
      req_instr0 = instr; req_a0 = a; req_b0 = b; vld0 = 1'b1;
    end else begin
      req_instr1 = instr; req_a1 = a; req_b1 = b; vld1 = 1'b1;
    end
    other0 = hs_count[1-p];
    got = 1'b0;
    waited = 0;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (req_ready[p] === 1'b1) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      chk($sformatf("hs_timeout_p%0d", p), req_ready[p], 1);
    end else begin
      cls = cls_of(instr[31:26]);
      r = alu_exec(cls, instr, a, b);
      e.port = p;
      e.c = r.c;
      e.br = (cls == 2) ? r.br : 1'b0;
      e.t = cyc;
      sb_q.push_back(e);
      hs_log.push_back(p);
      last_hs = cyc;
      last_hs_instr = instr;
      hs_count[p]++;
      chk($sformatf("starve_p%0d", p), (hs_count[1-p] - other0) <= 1, 1);
    end
    @(posedge clk);
    #1;
    if (p == 0) vld0 = 1'b0;
    else vld1 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || rsp_valid != 2'b00) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, (sb_q.size() == 0) && (rsp_valid == 2'b00), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, {req_ready, rsp_valid, rsp_branch, alu_rtype, alu_itype, alu_jtype}, 0);
    chk({name, "_rsp_c"}, rsp_c, 0);
    chk({name, "_alu_instr"}, alu_instruction, 0);
    chk({name, "_alu_a"}, alu_a, 0);
    chk({name, "_alu_b"}, alu_b, 0);
  endtask

  function automatic logic [63:0] pack_log();
    logic [63:0] v;
    v = '0;
    foreach (hs_log[i]) v = (v << 4) | 64'(hs_log[i] + 1);
    return v;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] ops[11] = '{6'd0, 6'd8, 6'd42, 6'd4, 6'd5, 6'd6, 6'd7, 6'd63, 6'd62, 6'd61, 6'd12};
    logic [5:0] funcs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    int         k;
    logic [5:0] op;
    logic [5:0] fn;
    k = $urandom_range(0, 11);
    op = (k == 11) ? 6'($urandom) : ops[k];
    k = $urandom_range(0, 5);
    fn = (k == 5) ? 6'($urandom) : funcs[k];
    return {op, 20'($urandom), fn};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int          h;
    int          n;
    int          i0, j0, r0;
    logic [31:0] ra, rb;
    rst = 1'b1;
    vld0 = 1'b0; vld1 = 1'b0;
    req_instr0 = '0; req_instr1 = '0;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    rr_rand = 1'b0;
    rr_dir = 2'b11;
    rr_rnd = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Port 0 add 5+7.
    r0 = rcnt;
    send(0, {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 32'd5, 32'd7);
    wait_idle("t1");
    chk("t1_add_c", last_c_port[0], 12);
    chk("t1_rtype_pulses", rcnt - r0, 1);

    // Both valid out of reset: port 0 addi first, then port 1 beq.
    rst = 1'b1;
    hs_log.delete();
    fork
      send(0, {6'b001000, 5'd1, 5'd2, 16'd4}, 32'd3, 32'd0);
      send(1, {6'b000100, 5'd1, 5'd2, 16'd8}, 32'd9, 32'd9);
      begin
        @(negedge clk);
        chk("t2_rst_gates_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    wait_idle("t2");
    chk("t2_order", pack_log(), 64'h12);
    chk("t2_p0_c", last_c_port[0], 7);
    chk("t2_p1_branch", last_br_port[1], 1);

    // Continuous requests on both ports alternate.
    do_reset();
    hs_log.delete();
    fork
      for (int i = 0; i < 3; i++) send(0, rnd_instr(), $urandom, $urandom);
      for (int i = 0; i < 3; i++) send(1, rnd_instr(), $urandom, $urandom);
    join
    wait_idle("t3");
    chk("t3_alternate", pack_log(), 64'h121212);

    // Port 1 response held off for 5 cycles while port 0 waits.
    do_reset();
    rr_dir = 2'b01;
    fork
      send(1, {6'b000111, 5'd1, 5'd2, 16'd2}, 32'd20, 32'd3);
      begin
        repeat (2) @(posedge clk);
        #1;
        send(0, {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 32'd100, 32'd1);
      end
      begin
        n = 0;
        while (rsp_valid[1] !== 1'b1 && n < 50) begin
          @(negedge clk);
          n++;
        end
        h = (rsp_valid[1] === 1'b1) ? 1 : 0;
        repeat (4) begin
          @(negedge clk);
          if (rsp_valid === 2'b10) h++;
        end
        chk("t4_hold_cycles", h, 5);
        @(posedge clk);
        #1;
        rr_dir = 2'b11;
      end
    join
    wait_idle("t4");
    chk("t4_p1_branch", last_br_port[1], 1);
    chk("t4_p0_c", last_c_port[0], 101);

    // Reset while the request is in ISSUE: discarded, outputs cleared.
    send(0, {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 32'd40, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("t5_mid_rst");
    h = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) h++;
    end
    chk("t5_no_rsp", h, 0);
    @(posedge clk);
    #1;

    // bne equal operands, then slti routed as itype.
    do_reset();
    j0 = jcnt;
    send(0, {6'b000101, 5'd1, 5'd2, 16'd3}, 32'd1, 32'd1);
    wait_idle("t6a");
    chk("t6_bne_branch", last_br_port[0], 0);
    chk("t6_jtype_pulses", jcnt - j0, 1);
    i0 = icnt;
    send(0, {6'b101010, 5'd1, 5'd2, 16'd5}, 32'hFFFF_FFFD, 32'd0);
    wait_idle("t6b");
    chk("t6_slti_itype", icnt - i0, 1);
    chk("t6_slti_c", last_c_port[0], 1);
    chk("t6_slti_branch", last_br_port[0], 0);

    // Randomized traffic on both ports with random response backpressure.
    do_reset();
    rr_rand = 1'b1;
    r0 = resp_count;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        ra = $urandom;
        rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
        send(0, rnd_instr(), ra, rb);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        ra = $urandom;
        rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
        send(1, rnd_instr(), ra, rb);
      end
    join
    rr_rand = 1'b0;
    rr_dir = 2'b11;
    wait_idle("rand");
    chk("rand_all_responded", resp_count - r0, 80);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
